// File: rtl/ps2_transmitter.sv
// ---------------------------------------------------------------------------------------------
// ps2_transmitter
//
// Host-to-device PS/2 transmitter. Sends one command byte to a keyboard using the
// inhibit / request-to-send / device-clocked frame, then checks the device acknowledge.
// Pins are driven open-drain by the top level from the *_low outputs.
//
// Ports:
//   CLK50MHz      in   system clock
//   RESET         in   synchronous, active-high reset
//   tx_data[7:0]  in   byte to send, latched when tx_start is accepted in IDLE
//   tx_start      in   one-cycle start strobe, honoured only in IDLE
//   tx_busy       out  high from the cycle after an accepted start until DONE
//   tx_done       out  one-cycle pulse at the end of a frame
//   tx_err        out  last frame had no ack (or timed out); cleared on next accepted start
//   rx_inhibit    out  copy of tx_busy, masks the PS/2 receiver while a frame is in flight
//   ps2_clk_in    in   raw PS/2 clock pin level (asynchronous)
//   ps2_data_in   in   raw PS/2 data pin level (asynchronous)
//   ps2_clk_low   out  1 = pull PS/2 clock low, 0 = release
//   ps2_data_low  out  1 = pull PS/2 data low, 0 = release
//
// Build option:
//   PS2_TX_TIMEOUT_EN  when defined, a watchdog started on entry to REQ aborts a frame after
//                      TIMEOUT_CYCLES cycles with tx_err set and a tx_done pulse. Without it a
//                      silent device holds the transmitter busy until RESET.
// ---------------------------------------------------------------------------------------------
module ps2_transmitter #(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned FILTER_LEN     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 750000
) (
    input  logic       CLK50MHz,
    input  logic       RESET,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err,
    output logic       rx_inhibit,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_low,
    output logic       ps2_data_low
);

    // -----------------------------------------------------------------------------------------
    // Constants
    // -----------------------------------------------------------------------------------------
    localparam int unsigned InhW  = $clog2(INHIBIT_CYCLES + 1);
    localparam int unsigned FiltW = $clog2(FILTER_LEN + 1);

    localparam logic [InhW-1:0]  InhLast  = InhW'(INHIBIT_CYCLES - 1);
    localparam logic [FiltW-1:0] FiltLast = FiltW'(FILTER_LEN - 1);

    localparam logic [2:0] StIdle     = 3'd0;
    localparam logic [2:0] StInhibit  = 3'd1;
    localparam logic [2:0] StReq      = 3'd2;
    localparam logic [2:0] StShift    = 3'd3;
    localparam logic [2:0] StAck      = 3'd4;
    localparam logic [2:0] StWaitIdle = 3'd5;
    localparam logic [2:0] StDone     = 3'd6;

    // -----------------------------------------------------------------------------------------
    // Input synchronizers (idle bus level is high, so they reset to 1)
    // -----------------------------------------------------------------------------------------
    logic clk_meta_q, clk_sync_q;
    logic data_meta_q, data_sync_q;

    always_ff @(posedge CLK50MHz) begin
        if (RESET) begin
            clk_meta_q  <= 1'b1;
            clk_sync_q  <= 1'b1;
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
        end else begin
            clk_meta_q  <= ps2_clk_in;
            clk_sync_q  <= clk_meta_q;
            data_meta_q <= ps2_data_in;
            data_sync_q <= data_meta_q;
        end
    end

    // -----------------------------------------------------------------------------------------
    // Clock glitch filter and falling-edge detector.
    // The filtered level only follows the synchronized pin after FILTER_LEN consecutive
    // samples that differ from it; fall_q pulses on the cycle the filtered level drops.
    // -----------------------------------------------------------------------------------------
    logic             clk_filt_q, clk_filt_d;
    logic [FiltW-1:0] filt_cnt_q, filt_cnt_d;
    logic             fall_q, fall_d;

    always_comb begin
        clk_filt_d = clk_filt_q;
        filt_cnt_d = '0;
        fall_d     = 1'b0;
        if (clk_sync_q != clk_filt_q) begin
            if (filt_cnt_q == FiltLast) begin
                clk_filt_d = clk_sync_q;
                fall_d     = ~clk_sync_q;
            end else begin
                filt_cnt_d = filt_cnt_q + FiltW'(1);
            end
        end
    end

    always_ff @(posedge CLK50MHz) begin
        if (RESET) begin
            clk_filt_q <= 1'b1;
            filt_cnt_q <= '0;
            fall_q     <= 1'b0;
        end else begin
            clk_filt_q <= clk_filt_d;
            filt_cnt_q <= filt_cnt_d;
            fall_q     <= fall_d;
        end
    end

    // -----------------------------------------------------------------------------------------
    // Frame state
    // -----------------------------------------------------------------------------------------
    logic [2:0]      state_q, state_d;
    logic [InhW-1:0] inh_cnt_q, inh_cnt_d;
    logic [3:0]      bitn_q, bitn_d;
    // {parity, D7..D0}; bit 0 is always the bit currently on the wire while shifting.
    logic [8:0]      shreg_q, shreg_d;
    logic            err_q, err_d;
    logic            wd_expired;

    // -----------------------------------------------------------------------------------------
    // Watchdog
    // -----------------------------------------------------------------------------------------
`ifdef PS2_TX_TIMEOUT_EN
    localparam int unsigned    WdW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT_CYCLES - 1);

    logic [WdW-1:0] wd_cnt_q, wd_cnt_d;
    logic           wd_active;

    // Counts every cycle spent waiting on the device, starting from 0 on the first REQ cycle.
    assign wd_active = (state_q == StReq) || (state_q == StShift) ||
                       (state_q == StAck) || (state_q == StWaitIdle);

    always_comb begin
        wd_cnt_d = wd_cnt_q;
        if (state_q == StInhibit) begin
            wd_cnt_d = '0;
        end else if (wd_active) begin
            wd_cnt_d = wd_cnt_q + WdW'(1);
        end
    end

    always_ff @(posedge CLK50MHz) begin
        if (RESET) begin
            wd_cnt_q <= '0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
        end
    end

    assign wd_expired = wd_active && (wd_cnt_q == WdLast);
`else
    // Keeps the parameter referenced when the watchdog is compiled out.
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES == 0);
    assign wd_expired     = 1'b0;
`endif

    // -----------------------------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        inh_cnt_d = inh_cnt_q;
        bitn_d    = bitn_q;
        shreg_d   = shreg_q;
        err_d     = err_q;

        case (state_q)
            StIdle: begin
                if (tx_start) begin
                    state_d   = StInhibit;
                    inh_cnt_d = '0;
                    err_d     = 1'b0;
                    shreg_d   = {~^tx_data, tx_data};
                end
            end
            StInhibit: begin
                if (inh_cnt_q == InhLast) begin
                    state_d = StReq;
                    bitn_d  = '0;
                end else begin
                    inh_cnt_d = inh_cnt_q + InhW'(1);
                end
            end
            StReq: begin
                // Start bit was sampled by the device; D0 goes out next.
                if (fall_q) begin
                    state_d = StShift;
                end
            end
            StShift: begin
                if (fall_q) begin
                    bitn_d  = bitn_q + 4'd1;
                    shreg_d = {1'b1, shreg_q[8:1]};
                    // Falling edge after parity: release data for the stop bit.
                    if (bitn_q == 4'd8) begin
                        state_d = StAck;
                    end
                end
            end
            StAck: begin
                if (fall_q) begin
                    err_d   = data_sync_q;
                    state_d = StWaitIdle;
                end
            end
            StWaitIdle: begin
                if (clk_filt_q && data_sync_q) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (wd_expired) begin
            state_d = StDone;
            err_d   = 1'b1;
        end
    end

    always_ff @(posedge CLK50MHz) begin
        if (RESET) begin
            state_q   <= StIdle;
            inh_cnt_q <= '0;
            bitn_q    <= '0;
            shreg_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            inh_cnt_q <= inh_cnt_d;
            bitn_q    <= bitn_d;
            shreg_q   <= shreg_d;
            err_q     <= err_d;
        end
    end

    // -----------------------------------------------------------------------------------------
    // Outputs, decoded from state so RESET releases both lines on the following cycle.
    // -----------------------------------------------------------------------------------------
    always_comb begin
        ps2_clk_low  = 1'b0;
        ps2_data_low = 1'b0;
        case (state_q)
            StInhibit: begin
                ps2_clk_low  = 1'b1;
                // Start bit is asserted in the last inhibit cycle so it is already
                // on the bus when the clock is released.
                ps2_data_low = (inh_cnt_q == InhLast);
            end
            StReq: begin
                ps2_data_low = 1'b1;
            end
            StShift: begin
                ps2_data_low = ~shreg_q[0];
            end
            default: begin
            end
        endcase
    end

    assign tx_busy    = (state_q != StIdle) && (state_q != StDone);
    assign tx_done    = (state_q == StDone);
    assign tx_err     = err_q;
    assign rx_inhibit = tx_busy;

endmodule

// File: tb/tb_ps2_transmitter.sv
// ---------------------------------------------------------------------------------------------
// tb_ps2_transmitter
//
// Drives ps2_transmitter against a behavioural PS/2 keyboard model on an open-drain bus.
// The stimulus pushes the expected outcome of each frame into a queue; the device model
// records the bits it sampled on rising clock edges; a monitor compares both against the
// expectation whenever tx_done pulses.
// ---------------------------------------------------------------------------------------------
module tb_ps2_transmitter;

    localparam int unsigned InhibitCycles = 200;
    localparam int unsigned FilterLen     = 4;
    localparam int unsigned TimeoutCycles = 3000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_start = 1'b0;
    logic       tx_busy, tx_done, tx_err, rx_inhibit;
    logic       ps2_clk_low, ps2_data_low;
    logic       ps2_clk_in, ps2_data_in;

    // Device side of the wired-AND bus
    logic dev_clk = 1'b1;
    logic dev_data = 1'b1;
    logic dev_ack = 1'b1;
    logic dev_silent = 1'b0;
    logic dev_abort = 1'b0;
    logic dev_active = 1'b0;
    int   dev_falls = 0;

    assign ps2_clk_in  = dev_clk & ~ps2_clk_low;
    assign ps2_data_in = dev_data & ~ps2_data_low;

    ps2_transmitter #(
        .INHIBIT_CYCLES(InhibitCycles),
        .FILTER_LEN    (FilterLen),
        .TIMEOUT_CYCLES(TimeoutCycles)
    ) dut (
        .CLK50MHz    (clk),
        .RESET       (rst),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done),
        .tx_err      (tx_err),
        .rx_inhibit  (rx_inhibit),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_clk_low (ps2_clk_low),
        .ps2_data_low(ps2_data_low)
    );

    // ---------------------------------------------------------------------------------------
    // Scoreboard
    // ---------------------------------------------------------------------------------------
    typedef struct {
        logic [7:0] data;
        logic       err;
        bit         check_bits;
    } exp_t;

    exp_t       exp_q[$];
    logic [9:0] obs_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Expected wire bits in device sampling order: D0..D7, odd parity, stop.
    function automatic logic [9:0] ref_frame(input logic [7:0] d);
        logic [9:0] f;
        int         ones;
        ones = 0;
        for (int i = 0; i < 8; i++) begin
            f[i] = d[i];
            ones += int'(d[i]);
        end
        f[8] = (ones % 2 == 0) ? 1'b1 : 1'b0;
        f[9] = 1'b1;
        return f;
    endfunction

    initial begin : monitor
        exp_t       e;
        logic [9:0] o;
        forever begin
            @(negedge clk);
            if (tx_done) begin
                check("done_busy_low", {31'd0, tx_busy}, 32'd0);
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_done: tx_done with no frame outstanding (cycle %0d)",
                             cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("frame_err", {31'd0, tx_err}, {31'd0, e.err});
                    if (e.check_bits) begin
                        n_checks++;
                        if (obs_q.size() == 0) begin
                            n_fail++;
                            $display("FAIL frame_bits: device saw no frame, want %03h",
                                     ref_frame(e.data));
                        end else begin
                            o = obs_q.pop_front();
                            n_checks--;
                            check("frame_bits", {22'd0, o}, {22'd0, ref_frame(e.data)});
                        end
                    end
                end
            end
        end
    end

    // ---------------------------------------------------------------------------------------
    // Keyboard model: waits for inhibit + request-to-send, then clocks 11 bits at a random
    // half period, samples data on rising edges and optionally acks on the 11th clock.
    // ---------------------------------------------------------------------------------------
    task automatic dev_frame();
        logic [9:0] bits;
        int         h;
        bits       = '0;
        h          = int'($urandom_range(25, 12));
        dev_falls  = 0;
        dev_active = 1'b1;
        repeat (h) @(negedge clk);
        for (int i = 1; i <= 11 && !dev_abort; i++) begin
            dev_clk = 1'b0;
            dev_falls++;
            repeat (h) @(negedge clk);
            dev_clk = 1'b1;
            if (i <= 10) bits = {ps2_data_in, bits[9:1]};
            if (i == 10) dev_data = ~dev_ack;
            if (i == 11) begin
                dev_data = 1'b1;
                if (!dev_abort) obs_q.push_back(bits);
            end
            repeat (h) @(negedge clk);
        end
        dev_clk    = 1'b1;
        dev_data   = 1'b1;
        dev_active = 1'b0;
    endtask

    initial begin : device
        int n;
        forever begin
            @(negedge clk);
            if (ps2_clk_low) begin
                n = 0;
                while (ps2_clk_low && n < 100000) begin
                    @(negedge clk);
                    n++;
                end
                if (ps2_data_low && !dev_silent) dev_frame();
            end
        end
    end

    // ---------------------------------------------------------------------------------------
    // Stimulus helpers
    // ---------------------------------------------------------------------------------------
    // Issues a start and checks the inhibit / request-to-send phase; returns at the first
    // cycle with the clock released (REQ entry).
    task automatic start_frame(input logic [7:0] d, input logic ack, input bit push,
                               input bit bits_valid, output int unsigned req_cyc);
        exp_t        e;
        int unsigned lo;
        int unsigned dl;
        logic        last_dl;
        @(negedge clk);
        tx_data   = d;
        tx_start  = 1'b1;
        dev_ack   = ack;
        dev_falls = 0;
        if (push) begin
            e.data       = d;
            e.err        = ~ack;
            e.check_bits = bits_valid;
            exp_q.push_back(e);
        end
        @(negedge clk);
        tx_start = 1'b0;
        tx_data  = 8'h00;
        check("start_busy", {31'd0, tx_busy}, 32'd1);
        check("start_rx_inhibit", {31'd0, rx_inhibit}, 32'd1);
        check("start_clk_low", {31'd0, ps2_clk_low}, 32'd1);
        check("start_err_cleared", {31'd0, tx_err}, 32'd0);
        lo      = 0;
        dl      = 0;
        last_dl = 1'b0;
        while (ps2_clk_low && lo < InhibitCycles + 10) begin
            lo++;
            if (ps2_data_low) dl++;
            last_dl = ps2_data_low;
            @(negedge clk);
        end
        check("inhibit_len", lo, InhibitCycles);
        check("inhibit_data_cycles", dl, 32'd1);
        check("inhibit_data_last", {31'd0, last_dl}, 32'd1);
        check("rts_data_low", {31'd0, ps2_data_low}, 32'd1);
        req_cyc = cyc;
    endtask

    task automatic wait_done(input int limit, input bit start_on_done, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge clk);
            if (tx_done) seen = 1'b1;
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL done_timeout: no tx_done within %0d cycles", limit);
        end else if (start_on_done) begin
            tx_data  = 8'h00;
            tx_start = 1'b1;
            @(negedge clk);
            tx_start = 1'b0;
            check("start_in_done_ignored", {31'd0, tx_busy}, 32'd0);
        end
    endtask

    task automatic wait_falls(input int target);
        int n;
        n = 0;
        while (dev_falls < target && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("device_falls_reached", dev_falls >= target, 32'd1);
    endtask

    // ---------------------------------------------------------------------------------------
    // Main sequence
    // ---------------------------------------------------------------------------------------
    initial begin : stimulus
        int unsigned rc;
        int unsigned quiet;
        bit          seen;
        logic [7:0]  d;
        logic        a;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_outputs",
              {26'd0, tx_busy, tx_done, tx_err, rx_inhibit, ps2_clk_low, ps2_data_low}, 32'd0);

        // Directed frames: ack, withheld ack, all-ones
        start_frame(8'hF4, 1'b1, 1'b1, 1'b1, rc);
        wait_done(2000, 1'b0, seen);
        start_frame(8'hED, 1'b0, 1'b1, 1'b1, rc);
        wait_done(2000, 1'b0, seen);
        start_frame(8'hFF, 1'b1, 1'b1, 1'b1, rc);
        wait_done(2000, 1'b0, seen);

        // Random frames
        for (int k = 0; k < 6; k++) begin
            d = 8'($urandom);
            a = 1'($urandom_range(1, 0));
            start_frame(d, a, 1'b1, 1'b1, rc);
            wait_done(2000, 1'b0, seen);
            repeat (int'($urandom_range(20, 1))) @(negedge clk);
        end

        // Start while busy is ignored; start in the DONE cycle is ignored
        start_frame(8'hF4, 1'b1, 1'b1, 1'b1, rc);
        wait_falls(3);
        @(negedge clk);
        tx_data  = 8'h00;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        wait_done(2000, 1'b1, seen);
        quiet = 0;
        repeat (300) begin
            @(negedge clk);
            if (ps2_clk_low || tx_busy) quiet++;
        end
        check("no_second_frame", quiet, 32'd0);

        // Reset mid-frame after the 4th falling edge
        start_frame(8'hA5, 1'b1, 1'b0, 1'b0, rc);
        wait_falls(4);
        repeat (3) @(negedge clk);
        dev_abort = 1'b1;
        rst       = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("reset_mid_release",
              {28'd0, ps2_clk_low, ps2_data_low, tx_busy, tx_done}, 32'd0);
        check("reset_mid_err", {31'd0, tx_err}, 32'd0);
        quiet = 0;
        while (dev_active && quiet < 3000) begin
            @(negedge clk);
            quiet++;
        end
        dev_abort = 1'b0;
        repeat (50) @(negedge clk);
        check("reset_stays_idle", {31'd0, tx_busy}, 32'd0);
        start_frame(8'hF4, 1'b1, 1'b1, 1'b1, rc);
        wait_done(2000, 1'b0, seen);

        // Silent device
        dev_silent = 1'b1;
`ifdef PS2_TX_TIMEOUT_EN
        start_frame(8'h55, 1'b0, 1'b1, 1'b0, rc);
        wait_done(TimeoutCycles + 100, 1'b0, seen);
        if (seen) begin
            check("timeout_latency", cyc - rc, TimeoutCycles);
            check("timeout_release", {30'd0, ps2_clk_low, ps2_data_low}, 32'd0);
            check("timeout_err", {31'd0, tx_err}, 32'd1);
        end
`else
        start_frame(8'h55, 1'b0, 1'b0, 1'b0, rc);
        repeat (TimeoutCycles + 1000) @(negedge clk);
        check("silent_still_busy", {31'd0, tx_busy}, 32'd1);
        check("silent_holds_start", {31'd0, ps2_data_low}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("silent_reset_idle", {29'd0, tx_busy, ps2_clk_low, ps2_data_low}, 32'd0);
`endif
        dev_silent = 1'b0;
        repeat (50) @(negedge clk);

        check("scoreboard_drained", exp_q.size(), 32'd0);
        check("device_queue_drained", obs_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : global_timeout
        #(2_000_000);
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "simulation time limit reached");
    end

endmodule
